// File: rtl/shift_pkg.sv
// shift_pkg: shared mode encodings, FSM states and widths for the shift units
package shift_pkg;
    localparam logic [2:0] SHIFT_BUF = 3'd0;
    localparam logic [2:0] SHIFT_LSL = 3'd1;
    localparam logic [2:0] SHIFT_LSR = 3'd2;
    localparam logic [2:0] SHIFT_ASR = 3'd3;
    localparam logic [2:0] SHIFT_ROL = 3'd4;
    localparam logic [2:0] SHIFT_ROR = 3'd5;
    localparam int SHIFT_AMT_W = 6;
    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
endpackage

// File: rtl/shift_iterative_step.sv
// shift_iterative_step: moves data by s positions (0..32) in the selected mode
module shift_iterative_step
    import shift_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]           data,
    input  logic [2:0]             mode,
    input  logic [SHIFT_AMT_W-1:0] s,
    input  logic                   sign,
    output logic [N-1:0]           result
);
    logic [2*N-1:0] rol_w;
    logic [2*N-1:0] ror_w;
    logic [N:0]     asr_w;
    // doubled words give wrap-around for rotates; the extra top bit carries the captured sign
    always_comb begin
        rol_w  = {data, data} << s;
        ror_w  = {data, data} >> s;
        asr_w  = $signed({sign, data}) >>> s;
        result = mode == SHIFT_LSL ? data << s :
                 mode == SHIFT_LSR ? data >> s :
                 mode == SHIFT_ASR ? asr_w[N-1:0] :
                 mode == SHIFT_ROL ? rol_w[2*N-1:N] :
                 mode == SHIFT_ROR ? ror_w[N-1:0] : data;
    end
endmodule

// File: rtl/shift_iterative.sv
// shift_iterative: multi-cycle handshaked shift/rotate unit moving at most STEP bits per cycle
module shift_iterative
    import shift_pkg::*;
#(
    parameter int STEP = 4,
    parameter int N    = 32
) (
    input  logic         iCLOCK,
    input  logic         iRESET_SYNC,
    input  logic         iFLUSH,
    input  logic         iVALID,
    output logic         oBUSY,
    input  logic [2:0]   iCONTROL_MODE,
    input  logic [N-1:0] iDATA_0,
    input  logic [N-1:0] iDATA_1,
    output logic         oVALID,
    input  logic         iBUSY,
    output logic [N-1:0] oDATA,
    output logic         oSF,
    output logic         oOF,
    output logic         oCF,
    output logic         oPF,
    output logic         oZF
);
    localparam logic [SHIFT_AMT_W-1:0] STEP_W = SHIFT_AMT_W'(STEP);
    state_t                 state;
    logic [N-1:0]           d;
    logic [2:0]             mode;
    logic                   sign;
    logic                   cf_q;
    logic [SHIFT_AMT_W-1:0] rem;
    logic [SHIFT_AMT_W-1:0] n;
    logic [SHIFT_AMT_W-1:0] eff;
    logic [SHIFT_AMT_W-1:0] s;
    logic [SHIFT_AMT_W-1:0] idx_l;
    logic [SHIFT_AMT_W-1:0] idx_r;
    logic                   n_zero;
    logic                   n_big;
    logic                   cf_in;
    logic [N-1:0]           moved;
    logic [N-1:0]           res_next;
    logic                   cf_next;
    logic                   unused_bits;
    assign n           = iDATA_1[SHIFT_AMT_W-1:0];
    assign unused_bits = ^iDATA_1[N-1:SHIFT_AMT_W];
    assign oBUSY       = state != IDLE;
    assign oOF         = 1'b0;
    // effective count and carry are derived from the request so RUN only has to move bits
    always_comb begin
        n_zero   = n == '0;
        n_big    = n > 6'd32;
        idx_l    = 6'd32 - n;
        idx_r    = n - 6'd1;
        eff      = (iCONTROL_MODE == SHIFT_LSL || iCONTROL_MODE == SHIFT_LSR || iCONTROL_MODE == SHIFT_ASR) ? (n_big ? 6'd32 : n) :
                   (iCONTROL_MODE == SHIFT_ROL || iCONTROL_MODE == SHIFT_ROR) ? {1'b0, n[4:0]} : '0;
        cf_in    = (iCONTROL_MODE == SHIFT_LSL || iCONTROL_MODE == SHIFT_ROL) ? (!n_zero && !n_big && iDATA_0[idx_l[4:0]]) :
                   (iCONTROL_MODE == SHIFT_LSR || iCONTROL_MODE == SHIFT_ROR) ? (!n_zero && !n_big && iDATA_0[idx_r[4:0]]) :
                   iCONTROL_MODE == SHIFT_ASR ? (n_zero ? 1'b0 : n_big ? iDATA_0[N-1] : iDATA_0[idx_r[4:0]]) : 1'b0;
        s        = rem > STEP_W ? STEP_W : rem;
        res_next = state == IDLE ? iDATA_0 : moved;
        cf_next  = state == IDLE ? cf_in : cf_q;
    end
    shift_iterative_step #(.N(N)) u_step (
        .data   (d),
        .mode   (mode),
        .s      (s),
        .sign   (sign),
        .result (moved)
    );
    // FSM: capture in IDLE, iterate in RUN, hold the registered result in OUT until accepted
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state  <= IDLE;
            oVALID <= 1'b0;
            oDATA  <= '0;
            oSF    <= 1'b0;
            oCF    <= 1'b0;
            oPF    <= 1'b0;
            oZF    <= 1'b0;
            d      <= '0;
            mode   <= SHIFT_BUF;
            sign   <= 1'b0;
            cf_q   <= 1'b0;
            rem    <= '0;
        end else if (iFLUSH) begin
            state  <= IDLE;
            oVALID <= 1'b0;
        end else begin
            case (state)
                IDLE: if (iVALID) begin
                    d     <= iDATA_0;
                    mode  <= iCONTROL_MODE;
                    sign  <= iDATA_0[N-1];
                    cf_q  <= cf_in;
                    rem   <= eff;
                    state <= eff == '0 ? OUT : RUN;
                end
                RUN: begin
                    d     <= moved;
                    rem   <= rem - s;
                    state <= rem == s ? OUT : RUN;
                end
                OUT: if (!iBUSY) begin
                    state  <= IDLE;
                    oVALID <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if ((state == IDLE && iVALID && eff == '0) || (state == RUN && rem == s)) begin
                oVALID <= 1'b1;
                oDATA  <= res_next;
                oSF    <= res_next[N-1];
                oPF    <= res_next[0];
                oZF    <= res_next == '0;
                oCF    <= cf_next;
            end
        end
    end
endmodule

// File: tb/tb_shift_iterative.sv
// tb_shift_iterative: scoreboard bench for the iterative shifter with directed vectors
module tb_shift_iterative;
    import shift_pkg::*;
    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC = 1'b1;
    logic        iFLUSH = 1'b0;
    logic        iVALID = 1'b0;
    logic        oBUSY;
    logic [2:0]  iCONTROL_MODE = 3'd0;
    logic [31:0] iDATA_0 = '0;
    logic [31:0] iDATA_1 = '0;
    logic        oVALID;
    logic        iBUSY = 1'b0;
    logic [31:0] oDATA;
    logic        oSF, oOF, oCF, oPF, oZF;

    typedef struct {
        logic [31:0] data;
        logic        cf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   last_consume = -100;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;

    shift_iterative #(.STEP(4), .N(32)) dut (
        .iCLOCK        (iCLOCK),
        .iRESET_SYNC   (iRESET_SYNC),
        .iFLUSH        (iFLUSH),
        .iVALID        (iVALID),
        .oBUSY         (oBUSY),
        .iCONTROL_MODE (iCONTROL_MODE),
        .iDATA_0       (iDATA_0),
        .iDATA_1       (iDATA_1),
        .oVALID        (oVALID),
        .iBUSY         (iBUSY),
        .oDATA         (oDATA),
        .oSF           (oSF),
        .oOF           (oOF),
        .oCF           (oCF),
        .oPF           (oPF),
        .oZF           (oZF)
    );

    always #5 iCLOCK = ~iCLOCK;
    always @(posedge iCLOCK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // monitor: every presented result is compared with the queue head; popped when accepted
    always @(negedge iCLOCK) begin
        if (oVALID) begin
            if (!prev_valid) rise_cyc = cyc;
            if (q.size() == 0) check("unexpected_valid", 32'(oVALID), 32'd0);
            else begin
                check("data", oDATA, q[0].data);
                check("cf", 32'(oCF), 32'(q[0].cf));
                check("sf", 32'(oSF), 32'(q[0].data[31]));
                check("pf", 32'(oPF), 32'(q[0].data[0]));
                check("zf", 32'(oZF), 32'(q[0].data == 32'd0));
                check("of", 32'(oOF), 32'd0);
                check("busy_in_out", 32'(oBUSY), 32'd1);
                if (!prev_valid) check("latency", 32'(rise_cyc - q[0].acc), 32'(q[0].lat));
                if (!iBUSY) begin
                    void'(q.pop_front());
                    last_consume = cyc + 1;
                end
            end
        end
        prev_valid = oVALID;
    end

    task automatic issue(input logic [2:0] m, input logic [31:0] d, input logic [31:0] n,
                         input logic [31:0] ed, input logic ecf, input int lat, input bit push,
                         output int acc);
        logic b;
        iCONTROL_MODE = m;
        iDATA_0 = d;
        iDATA_1 = n;
        iVALID = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge iCLOCK);
            b = oBUSY;
            @(posedge iCLOCK);
            #1;
            if (!b) begin
                acc = cyc;
                break;
            end
        end
        iVALID = 1'b0;
        if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
        else if (push) q.push_back('{ed, ecf, lat, acc});
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge iCLOCK);
        #1;
        check("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc2;
        int k;
        repeat (2) @(posedge iCLOCK);
        #1;
        iRESET_SYNC = 1'b0;
        check("rst_valid", 32'(oVALID), 32'd0);
        check("rst_busy", 32'(oBUSY), 32'd0);
        check("rst_data", oDATA, 32'd0);
        check("rst_flags", {27'd0, oSF, oOF, oCF, oPF, oZF}, 32'd0);

        issue(SHIFT_LSL, 32'h8000_0001, 32'd1,           32'h0000_0002, 1'b1, 1, 1'b1, acc);
        issue(SHIFT_ASR, 32'h8000_0000, 32'd40,          32'hFFFF_FFFF, 1'b1, 8, 1'b1, acc);
        issue(SHIFT_ROR, 32'h0000_0001, 32'd32,          32'h0000_0001, 1'b0, 0, 1'b1, acc);
        issue(SHIFT_ROR, 32'h0000_0001, 32'd33,          32'h8000_0000, 1'b0, 1, 1'b1, acc);
        issue(SHIFT_LSL, 32'hFFFF_FFFF, 32'hFFFF_FFE0,   32'h0000_0000, 1'b1, 8, 1'b1, acc);
        issue(SHIFT_ASR, 32'h7FFF_FFF0, 32'd3,           32'h0FFF_FFFE, 1'b0, 1, 1'b1, acc);
        drain();

        iBUSY = 1'b1;
        issue(SHIFT_LSR, 32'h0000_00F0, 32'd5, 32'h0000_0007, 1'b1, 2, 1'b1, acc);
        for (k = 0; k < 50 && !oVALID; k++) @(posedge iCLOCK) #1;
        check("stall_valid_seen", 32'(oVALID), 32'd1);
        repeat (3) @(posedge iCLOCK);
        #1;
        iBUSY = 1'b0;
        issue(SHIFT_ROL, 32'h1234_5678, 32'd8, 32'h3456_7812, 1'b0, 2, 1'b1, acc2);
        check("back_to_back", 32'(acc2), 32'(last_consume + 1));
        drain();

        issue(3'd7,      32'h0000_0000, 32'd9, 32'h0000_0000, 1'b0, 0, 1'b1, acc);
        issue(SHIFT_ROR, 32'h0000_000F, 32'd4, 32'hF000_0000, 1'b1, 1, 1'b1, acc);
        drain();

        issue(SHIFT_ROL, 32'hDEAD_BEEF, 32'd20, 32'd0, 1'b0, 0, 1'b0, acc);
        @(posedge iCLOCK);
        #1;
        iFLUSH = 1'b1;
        @(posedge iCLOCK);
        #1;
        iFLUSH = 1'b0;
        check("flush_busy", 32'(oBUSY), 32'd0);
        check("flush_valid", 32'(oVALID), 32'd0);
        repeat (10) @(posedge iCLOCK);
        #1;
        check("flush_quiet", 32'(oVALID), 32'd0);

        iFLUSH = 1'b1;
        iVALID = 1'b1;
        iCONTROL_MODE = SHIFT_LSL;
        iDATA_0 = 32'h1;
        iDATA_1 = 32'd8;
        @(posedge iCLOCK);
        #1;
        iFLUSH = 1'b0;
        iVALID = 1'b0;
        check("flush_idle_drop", 32'(oBUSY), 32'd0);

        issue(SHIFT_LSL, 32'hFFFF_FFFF, 32'd32, 32'd0, 1'b0, 0, 1'b0, acc);
        @(posedge iCLOCK);
        #1;
        iRESET_SYNC = 1'b1;
        @(posedge iCLOCK);
        #1;
        iRESET_SYNC = 1'b0;
        check("midrst_data", oDATA, 32'd0);
        check("midrst_flags", {27'd0, oSF, oOF, oCF, oPF, oZF}, 32'd0);
        check("midrst_valid", 32'(oVALID), 32'd0);
        check("midrst_busy", 32'(oBUSY), 32'd0);

        issue(SHIFT_LSR, 32'h0000_ABCD, 32'd0, 32'h0000_ABCD, 1'b0, 0, 1'b1, acc);
        drain();
        repeat (2) @(posedge iCLOCK);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
